// File: rtl/exu_pkg.sv
// exu_pkg: shared ExtUART definitions (FSM encoding, minimum bit period) for the Rx and Tx ends
package exu_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam int MIN_BAUD = 4;
endpackage

// File: rtl/exu_sync2.sv
// exu_sync2: parametric-width two-flop synchronizer, resets to all-ones (idle-high lines)
module exu_sync2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_m;
    logic [W-1:0] r_q;
    // two-stage capture of the asynchronous lanes
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_m <= '1;
            r_q <= '1;
        end else begin
            r_m <= i_d;
            r_q <= r_m;
        end
    assign o_q = r_q;
endmodule

// File: rtl/exu_rx_deser.sv
// exu_rx_deser: deserializes W_BUS-lane ExtUART frames into one word with done/error/timeout pulses
module exu_rx_deser
    import exu_pkg::*;
#(
    parameter int W_BUS = 8,
    parameter int N_DBT = 4,
    parameter int W_BAU = 16,
    parameter int S_TOT = 17
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [W_BAU-1:0]         baud,
    input  logic [W_BUS-1:0]         exu_rxd,
    output logic [W_BUS*N_DBT-1:0]   dat,
    output logic                     f_fin,
    output logic                     f_err,
    output logic                     f_tot,
    output logic                     busy
);
    localparam int W_BIT = $clog2(N_DBT + 1);
    localparam logic [W_BIT-1:0] LAST_BIT = W_BIT'(N_DBT - 1);
    localparam logic [S_TOT-1:0] TOT_PRE = {{(S_TOT-1){1'b1}}, 1'b0};
    logic [W_BUS-1:0]       w_s;
    logic [W_BAU-1:0]       w_p;
    logic                   w_half;
    logic                   w_full;
    state_t                 r_st;
    logic [W_BAU-1:0]       r_p;
    logic [W_BAU-1:0]       r_cnt;
    logic [W_BIT-1:0]       r_bit;
    logic [W_BUS*N_DBT-1:0] r_sh;
    logic [W_BUS*N_DBT-1:0] r_dat;
    logic [S_TOT-1:0]       r_idle;
    logic                   r_arm;
    logic                   r_fin;
    logic                   r_err;
    logic                   r_tot;
    logic                   r_busy;
    exu_sync2 #(.W(W_BUS)) u_sync (.clk(clk), .rst(rst), .i_d(exu_rxd), .o_q(w_s));
    assign w_p    = (baud < W_BAU'(MIN_BAUD)) ? W_BAU'(MIN_BAUD) : baud;
    assign w_half = r_cnt == (r_p >> 1) - 1'b1;
    assign w_full = r_cnt == r_p - 1'b1;
    // frame FSM: start detect, mid-bit sampling, stop check and idle-timeout tracking
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_st   <= IDLE;
            r_p    <= W_BAU'(MIN_BAUD);
            r_cnt  <= '0;
            r_bit  <= '0;
            r_sh   <= '0;
            r_dat  <= '0;
            r_idle <= '0;
            r_arm  <= 1'b0;
            r_fin  <= 1'b0;
            r_err  <= 1'b0;
            r_tot  <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_fin <= 1'b0;
            r_err <= 1'b0;
            r_tot <= 1'b0;
            case (r_st)
                IDLE:
                    if (~&w_s) begin
                        r_st   <= START;
                        r_cnt  <= '0;
                        r_bit  <= '0;
                        r_p    <= w_p;
                        r_busy <= 1'b1;
                        r_idle <= '0;
                    end else if (r_arm) begin
                        r_idle <= r_idle + 1'b1;
                        if (r_idle == TOT_PRE) begin
                            r_tot <= 1'b1;
                            r_arm <= 1'b0;
                        end
                    end
                START:
                    if (w_half) begin
                        r_cnt  <= '0;
                        r_st   <= ~|w_s ? DATA : IDLE;
                        r_busy <= ~|w_s;
                    end else
                        r_cnt <= r_cnt + 1'b1;
                DATA:
                    if (w_full) begin
                        r_sh[r_bit*W_BUS +: W_BUS] <= w_s;
                        r_cnt <= '0;
                        r_bit <= r_bit + 1'b1;
                        if (r_bit == LAST_BIT)
                            r_st <= STOP;
                    end else
                        r_cnt <= r_cnt + 1'b1;
                STOP:
                    if (w_full) begin
                        if (&w_s) begin
                            r_dat <= r_sh;
                            r_fin <= 1'b1;
                        end else
                            r_err <= 1'b1;
                        r_st   <= IDLE;
                        r_busy <= 1'b0;
                        r_idle <= '0;
                        r_arm  <= 1'b1;
                    end else
                        r_cnt <= r_cnt + 1'b1;
                default:
                    r_st <= IDLE;
            endcase
        end
    assign dat   = r_dat;
    assign f_fin = r_fin;
    assign f_err = r_err;
    assign f_tot = r_tot;
    assign busy  = r_busy;
endmodule
